gate_op_arbiter: RTL

- Shares one registered bitwise logic-op unit between NUM_REQ requesters using a round-robin arbiter.
- The unit supports AND, OR, XOR, NOT, NAND, NOR, XNOR and BUF.
- Each requester presents an opcode and two operands through a valid/ready handshake.
- The block returns the result and the requester ID through a valid/ready response port.
- Only one transaction is in flight at a time. This is the sequencing and sharing layer in front of the basic-gate datapath.

---
 rtl/gate_op_arbiter.sv | 77 +++++++
 1 files changed

// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter: round-robin sharing of one registered bitwise logic-op unit between NUM_REQ valid/ready requesters
module gate_op_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;
  logic [ID_W-1:0] rr_ptr, grant, id_q;
  logic found, take;
  logic [2:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, base, res;
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        grant = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end
  assign take = state == IDLE && found;
  assign req_ready = (rst_n && take) ? NUM_REQ'(1) << grant : '0;
  assign busy = state != IDLE;
  assign base = op_q[1:0] == 2'd0 ? a_q & b_q :
                op_q[1:0] == 2'd1 ? a_q | b_q :
                op_q[1:0] == 2'd2 ? a_q ^ b_q : a_q;
  assign res = (op_q[2] ^ (op_q[1:0] == 2'd3)) ? ~base : base;
  always_comb begin
    state_nxt = state;
    state_nxt = take ? EXEC :
                state == EXEC ? RESP :
                (state == RESP && rsp_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        op_q   <= req_op[3*grant +: 3];
        a_q    <= req_a[WIDTH*grant +: WIDTH];
        b_q    <= req_b[WIDTH*grant +: WIDTH];
        id_q   <= grant;
        rr_ptr <= (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
      end
      if (state == EXEC) begin
        rsp_data  <= res;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule
